fsmn_route: RTL and testbench
=============================

FSMN_ROUTE -- requirements
Module: fsmn_route

Interface
REQ-001 SHALL have parameter NCH, default 2: number of increment channels and number of decrement channels.
REQ-002 SHALL have parameter SW, default 2: state width.
REQ-003 SHALL have parameter NSTATES, default 4: state modulus; elaboration SHALL fail unless 2 <= NSTATES <= 2^SW and NCH < NSTATES.
REQ-004 SHALL have parameter INIT, default 0: state loaded by clear; elaboration SHALL fail unless INIT < NSTATES.
REQ-005 SHALL have port GCLK_Pad, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port reset_n_Pad, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port inc_Pad, input, NCH bits: increment pulses, one per channel.
REQ-008 SHALL have port dec_Pad, input, NCH bits: decrement pulses, one per channel.
REQ-009 SHALL have port clr_Pad, input, 1 bit: clear/arm pulse.
REQ-010 SHALL have port state_obs_Pad, output, SW bits: current state.
REQ-011 SHALL have port carry_Pad, output, 1 bit: wrap-up (or clamp-high) pulse.
REQ-012 SHALL have port borrow_Pad, output, 1 bit: wrap-down (or clamp-low) pulse.
REQ-013 SHALL have port run_obs_Pad, output, 1 bit: high while the controller is in RUN.

Function
REQ-014 SHALL sample all inputs on the GCLK_Pad rising edge; all outputs SHALL be registered, with 1-cycle latency.
REQ-015 SHALL compute net = popcount(inc_Pad) - popcount(dec_Pad) as a signed value of width clog2(NCH+1)+1.
REQ-016 SHALL implement a controller with two states, ARMED and RUN.
REQ-017 In ARMED: inc/dec SHALL be ignored, the state SHALL be held, and carry/borrow SHALL be 0; clr_Pad=1 SHALL load state=INIT and enter RUN.
REQ-018 In RUN with clr_Pad=0: next state SHALL be (state+net) mod NSTATES.
REQ-019 In RUN: carry_Pad SHALL be 1 for exactly one cycle when state+net >= NSTATES, and borrow_Pad SHALL be 1 for exactly one cycle when state+net < 0; otherwise both SHALL be 0.
REQ-020 In RUN, clr_Pad=1 SHALL take priority over inc/dec: state=INIT, carry=borrow=0, controller stays in RUN.
REQ-021 When inc and dec arrive in the same cycle, they SHALL cancel per net; net=0 SHALL hold the state with no pulses.
REQ-022 carry_Pad and borrow_Pad SHALL never be high in the same cycle.

Reset
REQ-023 reset_n_Pad low SHALL immediately force: controller=ARMED, state_obs_Pad=0, carry_Pad=0, borrow_Pad=0, run_obs_Pad=0.
REQ-024 Reset asserted mid-RUN SHALL discard the in-flight update; after release, the block SHALL require a clr_Pad pulse before counting.

Configuration
REQ-025 Macro FSMN_SAT_EN defined: arithmetic SHALL saturate: state+net > NSTATES-1 gives NSTATES-1 with carry_Pad=1, and state+net < 0 gives 0 with borrow_Pad=1.
REQ-026 Macro FSMN_SAT_EN undefined: modulo wrap per REQ-018/019.

Structure
REQ-027 Package fsmn_pkg SHALL hold the controller state enum (ARMED, RUN) and the clog2-based net-width function.
REQ-028 Sub-module fsmn_popcnt (NCH-bit population count, combinational) SHALL be instantiated twice, once for inc_Pad and once for dec_Pad.

Verification (defaults NCH=2, SW=2, NSTATES=4, INIT=0)
REQ-029 Reset, then inc_Pad=01 for 3 cycles with no clr -> state_obs_Pad=0, run_obs_Pad=0, no carry.
REQ-030 clr_Pad pulse, then inc_Pad=11 for 3 cycles -> state 0,2,0,2; carry_Pad=1 only on the 2->0 cycle.
REQ-031 In RUN at state 0, dec_Pad=11 -> state 2, borrow_Pad=1 for one cycle; with FSMN_SAT_EN -> state 0, borrow_Pad=1.
REQ-032 In RUN at state 1, inc_Pad=11 with dec_Pad=01 -> state 2, no pulses; inc_Pad=01 with dec_Pad=01 -> hold.
REQ-033 In RUN at state 3, clr_Pad=1 together with inc_Pad=11 -> state 0, carry_Pad=0.
REQ-034 In RUN at state 2, reset_n_Pad pulsed low between edges -> all outputs 0 at once; later inc pulses ignored until clr.

Source files
------------

// File: rtl/fsmn_pkg.sv
// Shared definitions for the fsmn_route up/down modulo counter.
// Holds the controller state type and the net-width helper.
package fsmn_pkg;

  typedef enum logic {
    ARMED = 1'b0,
    RUN   = 1'b1
  } ctrl_t;

  // Signed width able to hold popcount(inc) - popcount(dec) for nch channels.
  function automatic int net_width(input int nch);
    return $clog2(nch + 1) + 1;
  endfunction

endpackage

// File: rtl/fsmn_popcnt.sv
// Combinational population count of an N-bit vector.
module fsmn_popcnt #(
  parameter int unsigned N = 2
) (
  input  logic [N-1:0]             i_bits,
  output logic [$clog2(N+1)-1:0]   o_count
);

  localparam int CW = $clog2(N + 1);

  // Sum of set bits.
  always_comb begin
    o_count = '0;
    for (int unsigned i = 0; i < N; i++) begin
      o_count = o_count + CW'(i_bits[i]);
    end
  end

endmodule

// File: rtl/fsmn_route.sv
// Multi-channel up/down counter modulo NSTATES with an ARMED/RUN controller.
// Build option: define FSMN_SAT_EN to saturate at 0 / NSTATES-1 instead of wrapping.
module fsmn_route
  import fsmn_pkg::*;
#(
  parameter int NCH     = 2,
  parameter int SW      = 2,
  parameter int NSTATES = 4,
  parameter int INIT    = 0
) (
  input  logic           GCLK_Pad,
  input  logic           reset_n_Pad,
  input  logic [NCH-1:0] inc_Pad,
  input  logic [NCH-1:0] dec_Pad,
  input  logic           clr_Pad,
  output logic [SW-1:0]  state_obs_Pad,
  output logic           carry_Pad,
  output logic           borrow_Pad,
  output logic           run_obs_Pad
);

  localparam int NW   = net_width(NCH);
  localparam int PW   = NW - 1;
  // Two extra bits: one for NSTATES itself (up to 2^SW), one for sign.
  localparam int SUMW = ((SW > NW) ? SW : NW) + 2;
  localparam logic signed [SUMW-1:0] C_NST = SUMW'(NSTATES);
  localparam logic signed [SUMW-1:0] C_MAX = SUMW'(NSTATES - 1);

  if (NSTATES < 2 || NSTATES > (1 << SW) || NCH >= NSTATES) begin : g_bad_cfg
    $error("fsmn_route: need 2 <= NSTATES <= 2^SW and NCH < NSTATES");
  end
  if (INIT < 0 || INIT >= NSTATES) begin : g_bad_init
    $error("fsmn_route: INIT must be below NSTATES");
  end

  logic [PW-1:0]          w_pinc;
  logic [PW-1:0]          w_pdec;
  logic signed [NW-1:0]   w_net;
  logic signed [SUMW-1:0] w_sum;
  logic                   w_over;
  logic                   w_under;
  logic [SW-1:0]          w_state_next;

  ctrl_t         r_ctrl;
  logic [SW-1:0] r_state;
  logic          r_carry;
  logic          r_borrow;

  fsmn_popcnt #(.N(NCH)) u_pop_inc (.i_bits(inc_Pad), .o_count(w_pinc));
  fsmn_popcnt #(.N(NCH)) u_pop_dec (.i_bits(dec_Pad), .o_count(w_pdec));

  assign w_net   = $signed({1'b0, w_pinc}) - $signed({1'b0, w_pdec});
  assign w_sum   = $signed(SUMW'({1'b0, r_state})) + SUMW'(w_net);
  assign w_over  = (w_sum >= C_NST);
  assign w_under = w_sum[SUMW-1];

  // Next counter value; |net| < NSTATES so one correction step suffices.
  always_comb begin
    w_state_next = SW'(w_sum);
`ifdef FSMN_SAT_EN
    if (w_over)       w_state_next = SW'(C_MAX);
    else if (w_under) w_state_next = '0;
`else
    if (w_over)       w_state_next = SW'(w_sum - C_NST);
    else if (w_under) w_state_next = SW'(w_sum + C_NST);
`endif
  end

  // Controller and registered outputs.
  always_ff @(posedge GCLK_Pad or negedge reset_n_Pad) begin
    if (!reset_n_Pad) begin
      r_ctrl   <= ARMED;
      r_state  <= '0;
      r_carry  <= 1'b0;
      r_borrow <= 1'b0;
    end else begin
      case (r_ctrl)
        ARMED: begin
          r_carry  <= 1'b0;
          r_borrow <= 1'b0;
          if (clr_Pad) begin
            r_state <= SW'(INIT);
            r_ctrl  <= RUN;
          end
        end
        RUN: begin
          if (clr_Pad) begin
            r_state  <= SW'(INIT);
            r_carry  <= 1'b0;
            r_borrow <= 1'b0;
          end else begin
            r_state  <= w_state_next;
            r_carry  <= w_over;
            r_borrow <= w_under;
          end
        end
        default: begin
          r_ctrl   <= ARMED;
          r_carry  <= 1'b0;
          r_borrow <= 1'b0;
        end
      endcase
    end
  end

  assign state_obs_Pad = r_state;
  assign carry_Pad     = r_carry;
  assign borrow_Pad    = r_borrow;
  assign run_obs_Pad   = (r_ctrl == RUN);

endmodule

// File: tb/tb_fsmn_route.sv
// Scoreboard bench for fsmn_route at default parameters.
module tb_fsmn_route;

  localparam int NCH = 2;
  localparam int SW  = 2;
  localparam int NST = 4;
  localparam int INI = 0;

  typedef struct packed {
    logic [SW-1:0] st;
    logic          c;
    logic          b;
    logic          r;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NCH-1:0] inc, dec;
  logic          clr;
  logic [SW-1:0] st_o;
  logic          c_o, b_o, r_o;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t q[$];
  int   m_state = 0;
  bit   m_run   = 0;

  fsmn_route #(.NCH(NCH), .SW(SW), .NSTATES(NST), .INIT(INI)) dut (
    .GCLK_Pad      (clk),
    .reset_n_Pad   (rst_n),
    .inc_Pad       (inc),
    .dec_Pad       (dec),
    .clr_Pad       (clr),
    .state_obs_Pad (st_o),
    .carry_Pad     (c_o),
    .borrow_Pad    (b_o),
    .run_obs_Pad   (r_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one cycle of stimulus, predict with the model, compare after the edge.
  task automatic step(input logic [NCH-1:0] i_inc, input logic [NCH-1:0] i_dec, input logic i_clr);
    exp_t e;
    int   net, s;
    @(negedge clk);
    inc = i_inc; dec = i_dec; clr = i_clr;
    net = $countones(i_inc) - $countones(i_dec);
    e = '0;
    if (!m_run) begin
      if (i_clr) begin m_state = INI; m_run = 1; end
    end else if (i_clr) begin
      m_state = INI;
    end else begin
      s = m_state + net;
`ifdef FSMN_SAT_EN
      if (s >= NST) begin s = NST - 1; e.c = 1; end
      else if (s < 0) begin s = 0; e.b = 1; end
`else
      if (s >= NST) begin s = s - NST; e.c = 1; end
      else if (s < 0) begin s = s + NST; e.b = 1; end
`endif
      m_state = s;
    end
    e.st = SW'(m_state);
    e.r  = m_run;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 0) begin
      check("queue_empty", 1, 0);
    end else begin
      e = q.pop_front();
      check("state",  32'(st_o), 32'(e.st));
      check("carry",  32'(c_o),  32'(e.c));
      check("borrow", 32'(b_o),  32'(e.b));
      check("run",    32'(r_o),  32'(e.r));
      check("excl",   32'(c_o & b_o), 0);
    end
  endtask

  // Asynchronous reset pulse between edges; outputs must drop immediately.
  task automatic reset_pulse();
    @(negedge clk);
    inc = '0; dec = '0; clr = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_state",  32'(st_o), 0);
    check("rst_carry",  32'(c_o),  0);
    check("rst_borrow", 32'(b_o),  0);
    check("rst_run",    32'(r_o),  0);
    #1 rst_n = 1'b1;
    m_state = 0;
    m_run   = 0;
  endtask

  initial begin
    rst_n = 1'b0; inc = '0; dec = '0; clr = 1'b0;
    #2;
    check("init_state", 32'(st_o), 0);
    check("init_carry", 32'(c_o),  0);
    check("init_borrow",32'(b_o),  0);
    check("init_run",   32'(r_o),  0);
    #10 rst_n = 1'b1;

    // Ignored while ARMED.
    repeat (3) step(2'b01, 2'b00, 1'b0);
    // Arm, then double increments wrap.
    step(2'b00, 2'b00, 1'b1);
    repeat (3) step(2'b11, 2'b00, 1'b0);
    // From 2 to 0, then double decrement from 0.
    step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b11, 1'b0);
    // State 1: partial cancellation and full cancellation.
    step(2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b01, 1'b0);
    step(2'b01, 2'b01, 1'b0);
    step(2'b10, 2'b01, 1'b0);
    // Reach 3, then clear wins over increments.
    step(2'b00, 2'b00, 1'b1);
    step(2'b11, 2'b00, 1'b0);
    step(2'b01, 2'b00, 1'b0);
    step(2'b11, 2'b00, 1'b1);
    // Reach 2, reset mid-run, increments ignored until clear.
    step(2'b11, 2'b00, 1'b0);
    reset_pulse();
    repeat (2) step(2'b11, 2'b00, 1'b0);
    step(2'b00, 2'b00, 1'b1);
    step(2'b01, 2'b00, 1'b0);
    // Random traffic with occasional clears.
    for (int i = 0; i < 40; i++) begin
      step(NCH'($urandom), NCH'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
